shake_absorb_packer: RTL and testbench
======================================

# shake_absorb_packer

Absorb-side front end of the SHAKE256 core: accepts the message as a byte stream and packs it into rate-sized blocks in native Keccak lane order, applying SHAKE domain-separation padding (0x1F … 0x80). Each packed block is handed to the absorb/permutation stage over a valid/ready handshake. It is the input-side counterpart of the digest conversion stage. That stage maps native lane order to MSB-first output. This block maps a byte stream to native lane order, with byte k of a block at bits [8k+7:8k].

## Interface
- RATE_BITS, 1088: block width in bits. Must be a multiple of 8 and ≥ 16. NUM_BYTES = RATE_BITS/8.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  in_byte is valid this cycle.
- in_ready  out  1  block can accept a byte this cycle.
- in_byte  in  8  message byte.
- in_last  in  1  qualifies in_byte as the final message byte.
- empty_msg  in  1  single-cycle request to pad a zero-length message.
- blk_valid  out  1  blk_data and blk_last are valid.
- blk_ready  in  1  downstream accepts the block.
- blk_data  out  RATE_BITS  packed block; byte k at [8k+7:8k].
- blk_last  out  1  block carries padding; this is the final block of the message.

## Operation
- State: buffer[RATE_BITS], count (width clog2(NUM_BYTES+1)), pend_extra flag, FSM {FILL, PAD, EMIT}.
- **FILL**
  - in_ready=1.
  - On in_valid: buffer byte[count] ← in_byte, then count+1.
  - If !in_last and count+1 == NUM_BYTES: go to EMIT with blk_last=0.
  - If in_last and count+1 < NUM_BYTES: go to PAD with count+1.
  - If in_last and count+1 == NUM_BYTES: go to EMIT with blk_last=0 and set pend_extra=1. The block is full, so the padding goes in an extra block.
  - empty_msg is honoured only in FILL with count==0 and in_valid=0; it goes to PAD. Otherwise empty_msg is ignored. If in_valid and empty_msg are both asserted, in_valid wins and empty_msg is ignored.
- **PAD** (one cycle, in_ready=0)
  - byte[count] |= 0x1F.
  - byte[NUM_BYTES-1] |= 0x80.
  - blk_last ← 1; pend_extra ← 0; go to EMIT.
  - If count == NUM_BYTES-1, the two writes combine into a single byte 0x9F.
- **EMIT** (in_ready=0)
  - blk_valid=1; blk_data and blk_last are held stable until handshake.
  - On blk_valid && blk_ready: buffer ← 0 and count ← 0.
  - Then go to PAD if pend_extra, else go to FILL.
- Unused buffer bytes are always zero because the buffer is cleared on every emit.

## Timing
- Reset values: state=FILL, count=0, buffer=0, pend_extra=0, in_ready=1, blk_valid=0, blk_data=0, blk_last=0. Reset mid-block discards partial data and any pending block.
- Full-block latency: 136th byte accepted at edge t → blk_valid=1 in cycle t+1.
- Padded-block latency: last byte accepted at edge t → PAD in cycle t+1 → blk_valid in cycle t+2. empty_msg uses the same timing.
- Handshake completes on the edge where blk_valid && blk_ready.
  - Next state FILL: in_ready=1 in the following cycle.
  - Next state PAD (extra block): blk_valid again 2 cycles after the handshake.
- blk_valid never drops without a handshake. The block accepts no input bytes while blk_valid=1.
- Throughput: one byte per cycle in FILL. Per block, add 1 cycle minimum for EMIT and 1 more for PAD on final blocks.
- blk_ready held high constantly is legal; EMIT then lasts exactly 1 cycle.

## Test plan
- Message 0x61,0x62,0x63 with in_last on 0x63 → one block.
  - Bytes 0..2 = 61 62 63, byte 3 = 1F, byte 135 = 80, all other bytes 00, blk_last=1.
  - blk_valid 2 cycles after 0x63 is accepted.
- 135-byte message of 0xAA → one block: bytes 0..134 = AA, byte 135 = 9F, blk_last=1.
- 136-byte message of 0x55 → first block all 55 with blk_last=0, then a second block with byte 0 = 1F, byte 135 = 80, rest 00, blk_last=1.
- 300-byte incrementing message (byte i = i mod 256) → three blocks:
  - Block 0 holds bytes 0..135.
  - Block 1 holds bytes 136..271.
  - Block 2 holds bytes 272..299 at positions 0..27, with 1F at position 28, 80 at position 135, and blk_last=1.
- empty_msg pulse after reset → single block: byte 0 = 1F, byte 135 = 80, blk_last=1. A second empty_msg pulse while count=5 is ignored.
- Backpressure and reset:
  - Hold blk_ready=0 for 10 cycles during EMIT → blk_data/blk_last stable, in_ready=0 throughout.
  - Assert reset after 40 bytes → in_ready=1 and blk_valid=0 immediately. A subsequent "abc" message produces the clean block from the first scenario.

Source files
------------

// File: rtl/shake_absorb_packer.sv
// SHAKE256 absorb front end: packs a message byte stream into rate-sized blocks
// in native Keccak lane order (byte k at [8k+7:8k]) and applies 0x1F..0x80 padding.
module shake_absorb_packer #(
  parameter int RATE_BITS = 1088
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_byte,
  input  logic                 in_last,
  input  logic                 empty_msg,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_last
);

  localparam int NUM_BYTES = RATE_BITS / 8;
  localparam int CW        = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {FILL, PAD, EMIT} state_e;

  state_e               state_q, state_d;
  logic [RATE_BITS-1:0] buf_q, buf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 last_q, last_d;
  logic [CW-1:0]        cnt_inc;

  assign cnt_inc   = cnt_q + 1'b1;
  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = buf_q;
  assign blk_last  = last_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int k = 0; k < NUM_BYTES; k++) begin
            if (cnt_q == CW'(k)) buf_d[8*k +: 8] = in_byte;
          end
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(NUM_BYTES)) begin
            // A full block ending the message still needs an all-padding block.
            state_d = EMIT;
            last_d  = 1'b0;
            pend_d  = in_last;
          end else if (in_last) begin
            state_d = PAD;
          end
        end else if (empty_msg && cnt_q == '0) begin
          state_d = PAD;
        end
      end
      PAD: begin
        for (int k = 0; k < NUM_BYTES; k++) begin
          if (cnt_q == CW'(k)) buf_d[8*k +: 8] = buf_d[8*k +: 8] | 8'h1F;
        end
        // OR-ing keeps the 0x9F case when the pad byte is also the last byte.
        buf_d[RATE_BITS-1 -: 8] = buf_d[RATE_BITS-1 -: 8] | 8'h80;
        last_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = EMIT;
      end
      EMIT: begin
        if (blk_ready) begin
          buf_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = pend_q ? PAD : FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_shake_absorb_packer.sv
// Directed bench for shake_absorb_packer: table of messages plus hand-written
// sequences for empty messages, backpressure and mid-block reset.
module tb_shake_absorb_packer;

  localparam int RB = 1088;
  localparam int NB = RB / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last, empty_msg;
  logic [7:0]    in_byte;
  logic          blk_valid, blk_ready, blk_last;
  logic [RB-1:0] blk_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_b [NB];

  typedef struct {
    string      name;
    int         len;
    int         base;
    int         step;
    int         pad_pos;
    logic [7:0] b_last;
  } vec_t;

  vec_t vecs [5];

  shake_absorb_packer #(.RATE_BITS(RB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .empty_msg (empty_msg),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic check_block(input string nm, input logic exp_last);
    int bad;
    bad = -1;
    for (int k = 0; k < NB; k++)
      if (bad < 0 && blk_data[8*k +: 8] !== exp_b[k]) bad = k;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s data byte %0d: got %h, required %h", nm, bad, blk_data[8*bad +: 8], exp_b[bad]);
    end
    chk({nm, " last"}, 64'(blk_last), 64'(exp_last));
  endtask

  task automatic clear_exp();
    for (int k = 0; k < NB; k++) exp_b[k] = 8'h00;
  endtask

  task automatic wait_valid(input string nm, input int exp_wait);
    int w;
    w = 0;
    while (!blk_valid && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, " edges to blk_valid"}, 64'(w), 64'(exp_wait));
  endtask

  task automatic handshake();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int w;
    w = 0;
    while (!in_ready && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 8) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready timeout: got 0, required 1");
    end
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int rem;
    for (int i = 0; i < v.len; i++) begin
      send_byte(8'(v.base + v.step * i), i == v.len - 1);
      if ((i + 1) % NB == 0) begin
        for (int k = 0; k < NB; k++) exp_b[k] = 8'(v.base + v.step * (i + 1 - NB + k));
        wait_valid({v.name, " full"}, 0);
        check_block({v.name, " full"}, 1'b0);
        handshake();
      end
    end
    rem = v.len % NB;
    for (int k = 0; k < NB; k++)
      exp_b[k] = (k < rem) ? 8'(v.base + v.step * (v.len - rem + k)) : 8'h00;
    if (v.pad_pos != NB - 1) exp_b[v.pad_pos] = 8'h1F;
    exp_b[NB-1] = v.b_last;
    wait_valid({v.name, " final"}, 1);
    check_block({v.name, " final"}, 1'b1);
    handshake();
    chk({v.name, " idle blk_valid"}, 64'(blk_valid), 64'(0));
    chk({v.name, " idle in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    vecs[0] = '{"abc",   3,   'h61, 1, 3,   8'h80};
    vecs[1] = '{"aa135", 135, 'hAA, 0, 135, 8'h9F};
    vecs[2] = '{"55x136",136, 'h55, 0, 0,   8'h80};
    vecs[3] = '{"inc300",300, 0,    1, 28,  8'h80};
    vecs[4] = '{"one",   1,   'h00, 0, 1,   8'h80};

    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    empty_msg = 1'b0; blk_ready = 1'b0;
    #1;
    clear_exp();
    chk("reset in_ready", 64'(in_ready), 64'(1));
    chk("reset blk_valid", 64'(blk_valid), 64'(0));
    check_block("reset", 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vector(vecs[i]);

    // Empty message pulse.
    empty_msg = 1'b1;
    @(posedge clk); #1;
    empty_msg = 1'b0;
    clear_exp();
    exp_b[0] = 8'h1F; exp_b[NB-1] = 8'h80;
    wait_valid("empty", 1);
    check_block("empty", 1'b1);
    handshake();

    // empty_msg while count=5 must be ignored.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b0);
    empty_msg = 1'b1;
    @(posedge clk); #1;
    empty_msg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("empty ignored blk_valid", 64'(blk_valid), 64'(0));
    chk("empty ignored in_ready", 64'(in_ready), 64'(1));
    send_byte(8'h15, 1'b1);
    clear_exp();
    for (int k = 0; k < 6; k++) exp_b[k] = 8'(8'h10 + k);
    exp_b[6] = 8'h1F; exp_b[NB-1] = 8'h80;
    wait_valid("count5", 1);
    check_block("count5", 1'b1);
    handshake();

    // Backpressure: hold blk_ready low while offering bytes that must be refused.
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    clear_exp();
    exp_b[0] = 8'h61; exp_b[1] = 8'h62; exp_b[2] = 8'h63; exp_b[3] = 8'h1F; exp_b[NB-1] = 8'h80;
    wait_valid("bp", 1);
    in_valid = 1'b1; in_byte = 8'hEE; in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_block("bp hold", 1'b1);
      chk("bp blk_valid", 64'(blk_valid), 64'(1));
      chk("bp in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check_block("bp before hs", 1'b1);
    handshake();
    chk("bp after hs in_ready", 64'(in_ready), 64'(1));
    chk("bp after hs blk_valid", 64'(blk_valid), 64'(0));

    // Reset after 40 bytes discards the partial block.
    for (int i = 0; i < 40; i++) send_byte(8'(8'hC0 + i), 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midreset in_ready", 64'(in_ready), 64'(1));
    chk("midreset blk_valid", 64'(blk_valid), 64'(0));
    clear_exp();
    check_block("midreset", 1'b0);
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    run_vector(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
